// File: rtl/fetch_unit.sv
// Instruction prefetch stage: streams sequential word addresses to a 1-cycle RAM
// and queues returned {pc, instr} pairs in a small FIFO for decode.
module fetch_unit #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic [31:0]              addr_o,
  output logic                     we_o,
  input  logic [31:0]              data_i,
  input  logic                     redirect_i,
  input  logic [31:0]              redirect_pc_i,
  output logic [31:0]              instr_o,
  output logic [31:0]              pc_o,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW:0]   DEPTH_C = (CW + 1)'(DEPTH);
  localparam logic [CW-1:0] FULL    = CW'(DEPTH);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   req_pc_q, req_pc_d;
  logic          inflight_q, inflight_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [63:0]   mem_q [DEPTH];
  logic          issue, push, pop;
  logic          unused_pc_bits;

  assign unused_pc_bits = &{1'b0, redirect_pc_i[1:0]};

  // Credit counts the outstanding request, so a push can never find the FIFO full.
  assign issue = !redirect_i && (({1'b0, count_q} + (CW + 1)'(inflight_q)) < DEPTH_C);
  assign push  = inflight_q && !redirect_i;
  assign pop   = valid_o && ready_i;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    inflight_d = issue;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (redirect_i) begin
      fetch_pc_d = {redirect_pc_i[31:2], 2'b00};
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (issue) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
        req_pc_d   = fetch_pc_q;
      end
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= '0;
      inflight_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      if (push) mem_q[wr_ptr_q] <= {req_pc_q, data_i};
    end
  end

  assign addr_o          = fetch_pc_q;
  assign we_o            = 1'b0;
  assign valid_o         = (count_q != '0);
  assign {pc_o, instr_o} = mem_q[rd_ptr_q];
  assign count_o         = count_q;

  no_push_when_full: assert property (@(posedge clk) disable iff (!reset)
    !(push && (count_q == FULL)));

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: expected PCs are queued when a (re)start is
// driven and compared against each valid/ready handshake.
module tb_fetch_unit;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, redirect, ready, we, valid;
  logic [31:0] addr, data, redirect_pc, instr, pc;
  logic [2:0]  count;

  logic        reset6, we6, valid6;
  logic [31:0] addr6, data6, instr6, pc6;
  logic [2:0]  count6;

  fetch_unit #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .addr_o(addr), .we_o(we), .data_i(data),
    .redirect_i(redirect), .redirect_pc_i(redirect_pc), .instr_o(instr),
    .pc_o(pc), .valid_o(valid), .ready_i(ready), .count_o(count));

  fetch_unit #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut6 (
    .clk(clk), .reset(reset6), .addr_o(addr6), .we_o(we6), .data_i(data6),
    .redirect_i(1'b0), .redirect_pc_i(32'h0), .instr_o(instr6),
    .pc_o(pc6), .valid_o(valid6), .ready_i(1'b1), .count_o(count6));

  // RAM holds word[i] = i, read latency 1
  always @(posedge clk) begin
    data  <= addr >> 2;
    data6 <= addr6 >> 2;
  end

  int unsigned n_chk = 0;
  int unsigned n_pass = 0;
  logic [31:0] sb_q[$];
  logic [31:0] sb6[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic sb_load(input logic [31:0] start);
    sb_q.delete();
    for (int i = 0; i < 64; i++) sb_q.push_back(start + 32'(i) * 32'd4);
  endtask

  // Drive one cycle's inputs at negedge, then score any handshake the next edge will take.
  task automatic cycle(input logic rdy, input logic redir, input logic [31:0] rpc);
    logic [31:0] e;
    @(negedge clk);
    ready = rdy; redirect = redir; redirect_pc = rpc;
    #1;
    if (valid && ready) begin
      if (sb_q.size() == 0) chk("sb_extra", 32'(sb_q.size()), 32'd1);
      else begin
        e = sb_q.pop_front();
        chk("sb_pc", pc, e);
        chk("sb_instr", instr, e >> 2);
      end
    end
    if (redir) sb_load({rpc[31:2], 2'b00});
  endtask

  task automatic do_reset(input logic rdy);
    @(negedge clk);
    reset = 1'b0; ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
    #1;
    chk("rst_valid", valid, 0);
    chk("rst_count", count, 0);
    chk("rst_addr", addr, 32'h0);
    chk("rst_pc", pc, 0);
    chk("rst_instr", instr, 0);
    chk("rst_we", we, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1; ready = rdy;
    sb_load(32'h0);
  endtask

  initial begin
    logic [31:0] prev, e;
    bit seen;
    reset = 1'b0; reset6 = 1'b0; ready = 1'b0; redirect = 1'b0; redirect_pc = '0;

    // 1: reset release, streaming
    do_reset(1'b1);
    cycle(1, 0, 0);
    chk("t1_valid_e1", valid, 0);
    cycle(1, 0, 0);
    chk("t1_first_valid", valid, 1);
    chk("t1_first_pc", pc, 32'h0);
    for (int i = 0; i < 8; i++) begin
      cycle(1, 0, 0);
      chk("t1_stream_valid", valid, 1);
    end

    // 2: stall until full
    do_reset(1'b0);
    for (int i = 0; i < 10; i++) begin
      cycle(0, 0, 0);
      if (i >= 2) chk("t2_head_pc", pc, 32'h0);
    end
    chk("t2_count", count, 4);
    chk("t2_addr", addr, 32'h10);
    chk("t2_valid", valid, 1);

    // 3: drain from full, addresses step by 4
    prev = addr;
    for (int i = 0; i < 12; i++) begin
      cycle(1, 0, 0);
      chk("t3_valid", valid, 1);
      if (addr != prev) chk("t3_addr_step", addr, prev + 32'd4);
      prev = addr;
    end

    // 4: redirect while a request is in flight
    cycle(1, 1, 32'h103);
    cycle(1, 0, 0);
    chk("t4_valid_t1", valid, 0);
    chk("t4_addr_t1", addr, 32'h100);
    cycle(1, 0, 0);
    chk("t4_valid_t2", valid, 0);
    cycle(1, 0, 0);
    chk("t4_valid_t3", valid, 1);
    chk("t4_pc_t3", pc, 32'h100);
    for (int i = 0; i < 4; i++) cycle(1, 0, 0);

    // 5: back-to-back redirects, last wins
    cycle(1, 1, 32'h200);
    cycle(1, 1, 32'h300);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      cycle(1, 0, 0);
      if (valid) begin
        chk("t5_first_pc", pc, 32'h300);
        seen = 1'b1;
      end
    end
    chk("t5_seen", 32'(seen), 32'd1);
    for (int i = 0; i < 4; i++) cycle(1, 0, 0);

    // 6: wrap past the top of the address space, then async reset
    sb6 = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4};
    @(negedge clk);
    reset6 = 1'b1;
    for (int i = 0; i < 12 && sb6.size() > 0; i++) begin
      @(negedge clk);
      if (valid6) begin
        e = sb6.pop_front();
        chk("t6_pc", pc6, e);
        chk("t6_instr", instr6, e >> 2);
      end
    end
    chk("t6_delivered", 32'(4 - sb6.size()), 32'd4);
    @(posedge clk);
    #2 reset6 = 1'b0;
    #1;
    chk("t6_async_valid", valid6, 0);
    chk("t6_async_count", count6, 0);
    chk("t6_async_addr", addr6, 32'hFFFF_FFF8);
    chk("t6_async_pc", pc6, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
